uart_rx: RTL and testbench

8N1 UART receive-only block. It is the receiving counterpart of the team's 8N1 transmitter (uart_tx).
- Oversamples the asynchronous rx line.
- Validates the start bit and samples 8 data bits LSB-first at mid-bit.
- Checks the stop bit, then presents the byte with a one-cycle done strobe.
- Sits between the board rx pin and the byte-consuming logic.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sync.sv | 23 ++
 rtl/uart_rx.sv | 138 +++++++++++++
 tb/tb_uart_rx.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: FSM encoding, frame width, idle level.
package uart_pkg;

   localparam int   DATA_BITS    = 8;
   localparam int   OS_DEFAULT   = 16;
   localparam logic LINE_IDLE    = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_t;

   function automatic logic maj3(
      input logic a,
      input logic b,
      input logic c
   );
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pin.
module uart_rx_sync
   import uart_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic rx,
   output logic rx_s
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= LINE_IDLE;
         rx_s <= LINE_IDLE;
      end else begin
         meta <= rx;
         rx_s <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and framing-error detection.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority bit decisions.
module uart_rx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = OS_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rxbyte,
   output logic                 rxdone,
   output logic                 rxerror,
   output logic                 rxbusy
);

   localparam int PW = $clog2(OVERSAMPLE);
   localparam logic [PW-1:0] PH_HALF = PW'(OVERSAMPLE/2 - 1);
   localparam logic [PW-1:0] PH_FULL = PW'(OVERSAMPLE - 1);

   logic                 rx_s;
   state_t               state;
   logic [PW-1:0]        phase;
   logic [2:0]           bitcnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 active;
   logic                 tick;
   logic                 bitv;

   uart_rx_sync u_sync (
      .clk  (clk),
      .rst  (rst),
      .rx   (rx),
      .rx_s (rx_s)
   );

   assign active = (state == START) || (state == DATA) || (state == STOP);

`ifdef UART_RX_MAJORITY_EN
   localparam logic [PW-1:0] PH_ONE = PW'(1);

   logic s1;
   logic s0;
   logic late;

   // Third vote is the live rx_s one cycle after phase 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1   <= LINE_IDLE;
         s0   <= LINE_IDLE;
         late <= 1'b0;
      end else begin
         if (phase == PH_ONE) s1 <= rx_s;
         if (phase == '0)     s0 <= rx_s;
         late <= active && (phase == '0);
      end
   end

   assign tick = late;
   assign bitv = maj3(s1, s0, rx_s);
`else
   assign tick = (phase == '0);
   assign bitv = rx_s;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         phase   <= '1;
         bitcnt  <= '1;
         shreg   <= '1;
         rxbyte  <= '0;
         rxdone  <= 1'b0;
         rxerror <= 1'b0;
         rxbusy  <= 1'b0;
      end else begin
         rxdone  <= 1'b0;
         rxerror <= 1'b0;
         // Free-running bit timer while a frame is in flight.
         if (active) begin
            if (phase == '0) phase <= PH_FULL;
            else             phase <= phase - 1'b1;
         end
         unique case (state)
            IDLE: begin
               if (!rx_s) begin
                  state  <= START;
                  phase  <= PH_HALF;
                  rxbusy <= 1'b1;
               end
            end
            START: begin
               if (tick) begin
                  if (!bitv) begin
                     state  <= DATA;
                     bitcnt <= '0;
                  end else begin
                     state  <= IDLE;
                     rxbusy <= 1'b0;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  shreg  <= {bitv, shreg[DATA_BITS-1:1]};
                  bitcnt <= bitcnt + 1'b1;
                  if (bitcnt == 3'(DATA_BITS - 1)) state <= STOP;
               end
            end
            STOP: begin
               if (tick) begin
                  if (bitv) begin
                     rxbyte <= shreg;
                     rxdone <= 1'b1;
                     state  <= IDLE;
                     rxbusy <= 1'b0;
                  end else begin
                     rxerror <= 1'b1;
                     state   <= BREAK;
                  end
               end
            end
            BREAK: begin
               // Hold here so a held-low line is not read as frames.
               if (rx_s) begin
                  state  <= IDLE;
                  rxbusy <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               rxbusy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at OVERSAMPLE=16.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int OS = 16;
`ifdef UART_RX_MAJORITY_EN
   localparam int         LAT        = 156;
   localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
   localparam int         LAT        = 155;
   localparam logic [7:0] GLITCH_EXP = 8'h04;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic [7:0] rxbyte;
   logic       rxdone;
   logic       rxerror;
   logic       rxbusy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int t0     = 0;
   int t_a    = 0;
   int n_done = 0;
   int n_err  = 0;
   int         done_cyc[$];
   logic [7:0] done_byte[$];
   logic       prev_done = 1'b0;

   uart_rx #(.OVERSAMPLE(OS)) dut (
      .clk     (clk),
      .rst     (rst),
      .rx      (rx),
      .rxbyte  (rxbyte),
      .rxdone  (rxdone),
      .rxerror (rxerror),
      .rxbusy  (rxbusy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] qb(input int i);
      return (done_byte.size() > i) ? done_byte[i] : 8'hxx;
   endfunction

   function automatic int qc(input int i);
      return (done_cyc.size() > i) ? done_cyc[i] : -1;
   endfunction

   // Pulse monitor, sampled 2ns after each rising edge.
   always @(posedge clk) begin
      #2;
      if (rxdone || rxerror) check("excl", 32'(rxdone & rxerror), 0);
      if (rxdone) begin
         check("done_width", 32'(prev_done), 0);
         check("busy_fall", 32'(rxbusy), 0);
         n_done++;
         done_cyc.push_back(cyc);
         done_byte.push_back(rxbyte);
      end
      if (rxerror) n_err++;
      prev_done = rxdone;
   end

   task automatic send_bit(input logic b);
      repeat (OS) begin
         @(negedge clk);
         rx = b;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stp);
      @(negedge clk);
      rx = 1'b0;
      t0 = cyc;
      repeat (OS - 1) @(negedge clk);
      check("busy_mid", 32'(rxbusy), 1);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      rx  = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_byte", 32'(rxbyte), 0);
      check("rst_done", 32'(rxdone), 0);
      check("rst_err", 32'(rxerror), 0);
      check("rst_busy", 32'(rxbusy), 0);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      send_frame(8'hA5, 1'b1);
      check("a5_n", n_done, 1);
      check("a5_byte", 32'(qb(0)), 32'h A5);
      check("a5_lat", qc(0) - t0, LAT);
      check("a5_err", n_err, 0);
      repeat (OS) @(negedge clk);

      send_frame(8'h00, 1'b1);
      t_a = t0;
      send_frame(8'hFF, 1'b1);
      check("b2b_n", n_done, 3);
      check("b2b_byte0", 32'(qb(1)), 32'h00);
      check("b2b_byte1", 32'(qb(2)), 32'hFF);
      check("b2b_lat", qc(1) - t_a, LAT);
      check("b2b_gap", qc(2) - qc(1), 160);

      repeat (2 * OS) @(negedge clk);
      repeat (3) begin
         @(negedge clk);
         rx = 1'b0;
      end
      @(negedge clk);
      rx = 1'b1;
      repeat (2) @(negedge clk);
      check("gl_busy", 32'(rxbusy), 1);
      repeat (20) @(negedge clk);
      check("gl_idle", 32'(rxbusy), 0);
      check("gl_done", n_done, 3);
      check("gl_err", n_err, 0);

      send_frame(8'h55, 1'b0);
      repeat (40) @(negedge clk);
      check("brk_err", n_err, 1);
      check("brk_done", n_done, 3);
      check("brk_byte", 32'(rxbyte), 32'hFF);
      check("brk_busy", 32'(rxbusy), 1);
      send_bit(1'b1);
      send_bit(1'b1);
      check("brk_exit", 32'(rxbusy), 0);
      send_frame(8'h3C, 1'b1);
      check("3c_n", n_done, 4);
      check("3c_byte", 32'(qb(3)), 32'h3C);
      check("3c_err", n_err, 1);

      repeat (OS) @(negedge clk);
      send_bit(1'b0);
      repeat (4) send_bit(1'b1);
      repeat (8) @(negedge clk);
      check("mid_busy", 32'(rxbusy), 1);
      rst = 1'b1;
      @(negedge clk);
      check("mr_byte", 32'(rxbyte), 0);
      check("mr_busy", 32'(rxbusy), 0);
      check("mr_done", 32'(rxdone), 0);
      check("mr_err", 32'(rxerror), 0);
      rst = 1'b0;
      repeat (200) @(negedge clk);
      check("mr_nodone", n_done, 4);
      check("mr_noerr", n_err, 1);
      send_frame(8'h81, 1'b1);
      check("81_n", n_done, 5);
      check("81_byte", 32'(qb(4)), 32'h81);

      repeat (OS) @(negedge clk);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b0);
      repeat (8) begin
         @(negedge clk);
         rx = 1'b0;
      end
      @(negedge clk);
      rx = 1'b1;
      @(negedge clk);
      rx = 1'b0;
      repeat (6) @(negedge clk);
      repeat (5) send_bit(1'b0);
      send_bit(1'b1);
      check("sg_n", n_done, 6);
      check("sg_byte", 32'(qb(5)), 32'(GLITCH_EXP));
      check("sg_err", n_err, 1);

      repeat (2 * OS) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
